inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 124 ++++++++++++
 tb/tb_inst_fetch.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding imem read feeding a 2-entry {pc, inst} buffer; data is visible one cycle after ack.
// Backpressure: stall_in holds the head, and new requests stop while the buffer would be full; flush redirects and drops in-flight data.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_data_in,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic [31:0] flush_pc_in,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        valid_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;
    localparam logic [1:0] FULL = 2'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fb_entry_t;

    fb_entry_t   fb_q [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic [1:0]  count_nxt;
    logic [1:0]  state;
    logic [31:0] fetch_pc;
    logic [31:0] pc_inc;
    logic        push;
    logic        pop;

    assign valid_out = (count != 2'd0);
    assign pop       = valid_out && !stall_in && !flush_in;
    assign push      = (state == WAIT) && imem_ack_in && !flush_in;
    assign pc_inc    = fetch_pc + 32'd4;
    assign pc_out    = valid_out ? fb_q[rd_ptr].pc   : 32'h0;
    assign inst_out  = valid_out ? fb_q[rd_ptr].inst : 32'h0;

    always_comb begin
        count_nxt = count + 2'(push) - 2'(pop);
        if (flush_in) begin
            count_nxt = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fb_q[0]       <= '0;
            fb_q[1]       <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            count         <= 2'd0;
            state         <= IDLE;
            fetch_pc      <= RESET_PC;
            imem_req_out  <= 1'b0;
            imem_addr_out <= 32'h0;
        end else begin
            count <= count_nxt;
            if (flush_in) begin
                wr_ptr   <= 1'b0;
                rd_ptr   <= 1'b0;
                fetch_pc <= flush_pc_in;
            end else begin
                if (push) begin
                    fb_q[wr_ptr] <= '{pc: imem_addr_out, inst: imem_data_in};
                    wr_ptr       <= ~wr_ptr;
                    fetch_pc     <= pc_inc;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
            end

            // In WAIT fetch_pc tracks the outstanding address; in IDLE it is the next one to fetch.
            case (state)
                IDLE: begin
                    if (!flush_in && count_nxt < FULL) begin
                        state         <= WAIT;
                        imem_req_out  <= 1'b1;
                        imem_addr_out <= fetch_pc;
                    end
                end
                WAIT: begin
                    if (flush_in) begin
                        if (imem_ack_in) begin
                            state        <= IDLE;
                            imem_req_out <= 1'b0;
                        end else begin
                            state <= DROP;
                        end
                    end else if (imem_ack_in) begin
                        if (count_nxt < FULL) begin
                            imem_addr_out <= pc_inc;
                        end else begin
                            state        <= IDLE;
                            imem_req_out <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (imem_ack_in) begin
                        state        <= IDLE;
                        imem_req_out <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    imem_req_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized scoreboard bench for inst_fetch with a memory responder and a few directed scenarios.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in;
    logic [31:0] imem_data_in;
    logic        stall_in;
    logic        flush_in;
    logic [31:0] flush_pc_in;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        valid_out;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_pc;
    logic [31:0] w_inst;
    logic        w_valid;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
        .imem_ack_in(imem_ack_in), .imem_data_in(imem_data_in),
        .stall_in(stall_in), .flush_in(flush_in), .flush_pc_in(flush_pc_in),
        .pc_out(pc_out), .inst_out(inst_out), .valid_out(valid_out)
    );

    // Second instance exercising address wrap from the top of the address space.
    inst_fetch #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req_out(w_req), .imem_addr_out(w_addr),
        .imem_ack_in(w_req), .imem_data_in(~w_addr),
        .stall_in(1'b0), .flush_in(1'b0), .flush_pc_in(32'h0),
        .pc_out(w_pc), .inst_out(w_inst), .valid_out(w_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          mem_mode = 0;   // 0: zero-wait, 1: fixed 3-cycle latency, 2: random 0..3

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory responder
    initial begin : responder
        bit pending;
        int wl;
        pending      = 1'b0;
        wl           = 0;
        imem_ack_in  = 1'b0;
        imem_data_in = 32'h0;
        forever begin
            cyc();
            imem_ack_in  = 1'b0;
            imem_data_in = $urandom;
            if (!rst) begin
                pending = 1'b0;
            end else begin
                if (imem_req_out && !pending) begin
                    pending = 1'b1;
                    wl = (mem_mode == 0) ? 0 : (mem_mode == 1) ? 3 : int'($urandom_range(0, 3));
                end
                if (pending) begin
                    if (wl == 0) begin
                        imem_ack_in  = 1'b1;
                        imem_data_in = ~imem_addr_out;
                        pending      = 1'b0;
                    end else begin
                        wl--;
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    imem_ack_in = 1'b1;   // stray ack with no request outstanding
                end
            end
        end
    end

    // Monitor / scoreboard: fetched words must come out in program order, restarting at each redirect.
    initial begin : monitor
        bit          mon_out;
        int          epoch;
        int          cur_tag;
        logic [31:0] next_addr;
        logic        prev_rst, prev_req, prev_ack;
        logic [31:0] prev_addr;
        exp_t        e;
        mon_out = 1'b0; epoch = 0; cur_tag = 0; next_addr = RESET_PC;
        prev_rst = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_req", imem_req_out, 32'h0);
                chk("rst_addr", imem_addr_out, 32'h0);
                chk("rst_valid", valid_out, 32'h0);
                chk("rst_pc", pc_out, 32'h0);
                chk("rst_inst", inst_out, 32'h0);
                exp_q.delete();
                epoch++;
                next_addr = RESET_PC;
                mon_out   = 1'b0;
            end else begin
                if (prev_rst && prev_req && !prev_ack) begin
                    chk("req_hold", imem_req_out, 32'h1);
                    chk("addr_hold", imem_addr_out, prev_addr);
                end
                chk("valid_vs_model", valid_out, (exp_q.size() != 0) ? 32'h1 : 32'h0);
                if (!valid_out) begin
                    chk("pc_zero", pc_out, 32'h0);
                    chk("inst_zero", inst_out, 32'h0);
                end
                if (imem_req_out && !mon_out) begin
                    chk("req_addr", imem_addr_out, next_addr);
                    mon_out = 1'b1;
                    cur_tag = epoch;
                end
                if (valid_out && !stall_in && !flush_in && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("pop_pc", pc_out, e.pc);
                    chk("pop_inst", inst_out, e.inst);
                end
                if (imem_ack_in && mon_out) begin
                    if (!flush_in && cur_tag == epoch) begin
                        exp_q.push_back('{pc: imem_addr_out, inst: imem_data_in});
                        next_addr = imem_addr_out + 32'd4;
                    end
                    mon_out = 1'b0;
                end
                if (flush_in) begin
                    exp_q.delete();
                    epoch++;
                    next_addr = flush_pc_in;
                end
            end
            prev_rst  = rst;
            prev_req  = imem_req_out;
            prev_ack  = imem_ack_in;
            prev_addr = imem_addr_out;
        end
    end

    // Holds reset for three cycles, releases it, and returns #1 after the first edge out of reset.
    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        cyc();
        chk("first_req", imem_req_out, 32'h1);
        chk("first_addr", imem_addr_out, RESET_PC);
    endtask

    initial begin : stim
        int i;
        rst = 1'b1; stall_in = 1'b0; flush_in = 1'b0; flush_pc_in = 32'h0;
        #2;

        // Reset release, zero-wait memory, and wrap on the second instance
        mem_mode = 0;
        do_reset();
        chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_second_req", w_req, 32'h1);
        chk("wrap_second_addr", w_addr, 32'h0000_0000);
        repeat (30) cyc();

        // Stall from reset: buffer fills, requests stop, head stays at pc 0
        stall_in = 1'b1;
        do_reset();
        repeat (9) cyc();
        chk("stall_req_off", imem_req_out, 32'h0);
        chk("stall_valid", valid_out, 32'h1);
        chk("stall_pc", pc_out, 32'h0);
        chk("stall_inst", inst_out, 32'hFFFF_FFFF);
        stall_in = 1'b0;
        repeat (20) cyc();

        // Flush while a slow request is outstanding
        mem_mode = 1;
        stall_in = 1'b1;
        do_reset();
        for (i = 0; i < 50 && !(valid_out && imem_req_out && imem_addr_out == 32'h4); i++) cyc();
        chk("drop_setup", (valid_out && imem_req_out && imem_addr_out == 32'h4) ? 32'h1 : 32'h0, 32'h1);
        flush_in = 1'b1; flush_pc_in = 32'h0000_0100;
        cyc();
        flush_in = 1'b0; stall_in = 1'b0;
        chk("drop_valid", valid_out, 32'h0);
        chk("drop_req_held", imem_req_out, 32'h1);
        chk("drop_addr_held", imem_addr_out, 32'h4);
        for (i = 0; i < 50 && !(imem_req_out && imem_addr_out == 32'h100); i++) cyc();
        chk("redirect_addr", imem_addr_out, 32'h100);
        for (i = 0; i < 50 && !valid_out; i++) cyc();
        chk("redirect_first_pc", pc_out, 32'h100);
        repeat (10) cyc();

        // Flush coincident with ack while stalled
        mem_mode = 0;
        do_reset();
        cyc();
        stall_in = 1'b1; flush_in = 1'b1; flush_pc_in = 32'h0000_0200;
        cyc();
        flush_in = 1'b0;
        chk("flush_ack_valid", valid_out, 32'h0);
        chk("flush_ack_req", imem_req_out, 32'h0);
        cyc();
        chk("flush_ack_next_req", imem_req_out, 32'h1);
        chk("flush_ack_next_addr", imem_addr_out, 32'h200);
        stall_in = 1'b0;
        repeat (10) cyc();

        // Reset asserted mid-request at address 8
        do_reset();
        for (i = 0; i < 50 && !(imem_req_out && imem_addr_out == 32'h8); i++) cyc();
        chk("midreset_setup", imem_addr_out, 32'h8);
        #3;
        rst = 1'b0;
        #1;
        chk("midreset_req", imem_req_out, 32'h0);
        chk("midreset_addr", imem_addr_out, 32'h0);
        chk("midreset_valid", valid_out, 32'h0);
        chk("midreset_pc", pc_out, 32'h0);
        chk("midreset_inst", inst_out, 32'h0);
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            mem_mode    = (n < 500) ? 0 : 2;
            stall_in    = ($urandom_range(0, 9) < 3);
            flush_in    = ($urandom_range(0, 19) == 0);
            flush_pc_in = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
            cyc();
        end
        stall_in = 1'b0; flush_in = 1'b0;
        repeat (20) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
